// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline stage register with skid buffer.
//   - state_t     : occupancy of a stage (EMPTY / FULL / SKID)
//   - CTRL_BUBBLE : value of one control bit in a bubble. It is replicated to
//                   the control width by the user, so a bubble is all zeros.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // EMPTY : no valid entry
  // FULL  : main entry valid, skid entry empty
  // SKID  : main and skid entries both valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  // Replicate to CTRL_W bits: {CTRL_W{CTRL_BUBBLE}}.
  localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in  1  clock, rising edge
//     rst   in  1  asynchronous active-high reset, clears the count
//     inc   in  1  count one event this cycle
//     count out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Pipeline stage register with valid/ready handshake and a one-entry skid
//   buffer. It is used at every stage boundary of the MIPS pipeline so each
//   boundary supports back-pressure, bubbles and squash at full throughput.
//   Control bits are cleared on reset, flush and bubble, so a killed
//   instruction can never write the register file or memory.
//
//   Parameters:
//     DATA_W  payload width (never cleared by flush)
//     CTRL_W  control-bit width (zeroed on reset, flush, bubble)
//     CNT_W   width of each statistics counter
//   Ports:
//     clk        in   1       clock, rising edge
//     rst        in   1       asynchronous active-high reset
//     flush      in   1       synchronous squash of all held entries
//     in_valid   in   1       upstream entry present
//     in_ready   out  1       stage can accept (registered)
//     in_data    in   DATA_W  upstream payload
//     in_ctrl    in   CTRL_W  upstream control bits
//     out_valid  out  1       downstream entry present
//     out_ready  in   1       downstream accepts
//     out_data   out  DATA_W  held payload
//     out_ctrl   out  CTRL_W  held control, 0 whenever out_valid = 0
//     stall_cnt  out  CNT_W   cycles with out_valid & !out_ready
//     flush_cnt  out  CNT_W   flushes that killed at least one valid entry
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CTRL_W-1:0] BUBBLE = {CTRL_W{CTRL_BUBBLE}};

  state_t              state_q;
  state_t              state_d;
  logic                ready_q;

  logic [DATA_W-1:0]   main_data_p1;
  logic [CTRL_W-1:0]   main_ctrl_p1;
  logic [DATA_W-1:0]   skid_data_p1;
  logic [CTRL_W-1:0]   skid_ctrl_p1;

  logic                main_vld;
  logic                accept;
  logic                drain;
  logic                load_in_main;
  logic                load_skid_main;
  logic                load_in_skid;
  logic                stall_inc;
  logic                flush_inc;

  // The state encodes both valid bits: main is valid outside EMPTY, skid is
  // valid only in SKID. Keeping them in one register makes an inconsistent
  // pair (skid valid, main empty) unrepresentable.
  assign main_vld = (state_q != EMPTY);
  assign accept   = in_valid & ready_q;
  assign drain    = main_vld & out_ready;

  always_comb begin
    state_d        = state_q;
    load_in_main   = 1'b0;
    load_skid_main = 1'b0;
    load_in_skid   = 1'b0;
    if (flush) begin
      // Squash wins: any concurrent accept is dropped.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = FULL;
            load_in_main = 1'b1;
          end
        end
        FULL: begin
          if (accept && drain) begin
            load_in_main = 1'b1;
          end else if (accept) begin
            state_d      = SKID;
            load_in_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so no accept can coincide with the drain.
          if (drain) begin
            state_d        = FULL;
            load_skid_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so there is no combinational
  // path from out_ready to in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID);
    end
  end

  // ---- stage p1: main entry (drives outputs) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_p1 <= '0;
      main_ctrl_p1 <= BUBBLE;
    end else if (flush) begin
      main_ctrl_p1 <= BUBBLE;
    end else if (load_in_main) begin
      main_data_p1 <= in_data;
      main_ctrl_p1 <= in_ctrl;
    end else if (load_skid_main) begin
      main_data_p1 <= skid_data_p1;
      main_ctrl_p1 <= skid_ctrl_p1;
    end
  end

  // ---- stage p1: skid entry (absorbs the entry in flight when out_ready drops) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data_p1 <= '0;
      skid_ctrl_p1 <= BUBBLE;
    end else if (flush) begin
      skid_ctrl_p1 <= BUBBLE;
    end else if (load_in_skid) begin
      skid_data_p1 <= in_data;
      skid_ctrl_p1 <= in_ctrl;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_vld;
  assign out_data  = main_data_p1;
  assign out_ctrl  = main_vld ? main_ctrl_p1 : BUBBLE;

  // A stall is counted even in a flush cycle; a flush is counted only when
  // it actually killed something.
  assign stall_inc = main_vld & ~out_ready;
  assign flush_inc = flush & main_vld;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [SAT_W-1:0]  s_stall_cnt;
  logic [SAT_W-1:0]  s_flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Same stimulus, narrow counters to exercise saturation.
  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: the stage is a FIFO of at most two entries whose head
  // is presented downstream; it accepts only while it holds fewer than two.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  entry_t q[$];
  bit     m_ready;
  int     m_stall, m_flush, m_sstall, m_sflush;
  int     n_cmp = 0;
  int     n_fail = 0;

  function automatic int sat_inc(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_ready = 1'b1;
    m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
  endtask

  // Advance the model using the inputs as they stand before the edge,
  // then let the edge happen and settle.
  task automatic cycle();
    bit     acc, drn;
    entry_t e;
    acc = in_valid && m_ready;
    drn = (q.size() > 0) && out_ready;
    e.d = in_data;
    e.c = in_ctrl;
    if (q.size() > 0 && !out_ready) begin
      m_stall  = sat_inc(m_stall, CNT_W);
      m_sstall = sat_inc(m_sstall, SAT_W);
    end
    if (flush) begin
      if (q.size() > 0) begin
        m_flush  = sat_inc(m_flush, CNT_W);
        m_sflush = sat_inc(m_sflush, SAT_W);
      end
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    rst = 1'b1;
    #2;
    model_clear();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    rst = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_out_ctrl: got %0h expected 0", out_ctrl); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    n_cmp++; if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    logic [CTRL_W-1:0] c;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = CTRL_W'($urandom_range(1, 255));
      in_valid = 1'b1;
      in_data  = 32'h10 + 32'(i);
      in_ctrl  = c;
      cycle();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, out_data, 32'h10 + 32'(i)); end
      n_cmp++; if (out_ctrl !== c) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %0h expected %0h", i, out_ctrl, c); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_tail_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL stream_tail_ctrl: got %0h expected 0", out_ctrl); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h20; in_ctrl = 8'h11;
    cycle();
    out_ready = 1'b0; in_data = 32'h21; in_ctrl = 8'h12;
    cycle();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %0b expected 0", in_ready); end
    in_data = 32'h22; in_ctrl = 8'h13;
    cycle();
    cycle();
    n_cmp++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
    n_cmp++; if (out_data !== 32'h20) begin n_fail++; $display("FAIL bp_held_data: got %0h expected 20", out_data); end
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h21) begin n_fail++; $display("FAIL bp_skid_out: got v=%0b d=%0h expected v=1 d=21", out_valid, out_data); end
    n_cmp++; if (out_ctrl !== 8'h12) begin n_fail++; $display("FAIL bp_skid_ctrl: got %0h expected 12", out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %0b expected 1", in_ready); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_flush_skid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
    in_data = 32'h30; cycle();
    in_data = 32'h31; cycle();
    flush = 1'b1; in_data = 32'h32; cycle();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL flush_out_ctrl: got %0h expected 0", out_ctrl); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt_one: got %0d expected 1", flush_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emerge[%0d]: got %0b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_flush_empty();
    flush = 1'b1; in_valid = 1'b0;
    cycle();
    flush = 1'b0;
    n_cmp++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_empty_cnt: got %0d expected 1", flush_cnt); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_state: got v=%0b r=%0b expected v=0 r=1", out_valid, in_ready); end
    in_valid = 1'b1; in_data = 32'h3A; in_ctrl = 8'h07;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h3A) begin n_fail++; $display("FAIL flush_empty_reload: got v=%0b d=%0h expected v=1 d=3a", out_valid, out_data); end
    cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40; in_ctrl = 8'hA5;
    cycle();
    cycle();
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b1; in_data = 32'h41; in_ctrl = 8'h5A;
    cycle();
    n_cmp++; if (out_valid !== 1'b1 || stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      n_fail++; $display("FAIL arst_pre: got v=%0b s=%0d f=%0d expected v=1 s=2 f=1", out_valid, stall_cnt, flush_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL arst_out_ctrl: got %0h expected 0", out_ctrl); end
    n_cmp++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_counters: got s=%0d f=%0d expected 0 0", stall_cnt, flush_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %0b expected 1", in_ready); end
    model_clear();
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h50; in_ctrl = 8'h3C;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d expected 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL wide_stall_cnt: got %0d expected 20", stall_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h50) begin n_fail++; $display("FAIL sat_held: got v=%0b d=%0h expected v=1 d=50", out_valid, out_data); end
  endtask

  task automatic test_random();
    logic              ev;
    logic [CTRL_W-1:0] ec;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      in_ctrl   = CTRL_W'($urandom);
      cycle();
      ev = (q.size() > 0);
      ec = ev ? q[0].c : 8'h00;
      n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, ev); end
      n_cmp++; if (out_ctrl !== ec) begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got %0h expected %0h", i, out_ctrl, ec); end
      if (ev) begin
        n_cmp++; if (out_data !== q[0].d) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, out_data, q[0].d); end
      end
      n_cmp++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %0b expected %0b", i, in_ready, m_ready); end
      n_cmp++; if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got s=%0d f=%0d expected s=%0d f=%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      n_cmp++; if (s_stall_cnt !== SAT_W'(m_sstall) || s_flush_cnt !== SAT_W'(m_sflush)) begin
        n_fail++; $display("FAIL rnd_sat_cnt[%0d]: got s=%0d f=%0d expected s=%0d f=%0d", i, s_stall_cnt, s_flush_cnt, m_sstall, m_sflush);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_skid();
    test_flush_empty();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and saturating stall/flush counters. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so every stage boundary of the MIPS pipeline supports back-pressure, bubble insertion and squash without losing throughput. Control fields are always cleared on reset, flush and bubble, so a killed instruction can never write the register file or memory.

## Interface
- DATA_W, 32, payload width (operands, register indices, offset); never cleared by flush
- CTRL_W, 8, control-bit width (RegWrite, MemWrite, MemRead, ...); zeroed on reset, flush and bubble
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept (registered)
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  held payload
- out_ctrl  out  CTRL_W  held control; 0 whenever out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  flushes that killed at least one valid entry

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry has a valid bit, data and ctrl.
- States: EMPTY (no valid entry), FULL (main only), SKID (main and skid).
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- EMPTY: accept -> FULL, load main.
- FULL: accept & drain -> FULL, main reloads. Accept & !drain -> SKID, input goes to skid. Drain & !accept -> EMPTY.
- SKID: drain -> FULL, skid moves to main. Accept cannot occur in this state.
- in_ready = (state != SKID). It is driven from a register and has no combinational path from out_ready.
- Flush takes priority over everything that cycle. Next state is EMPTY, both valid bits clear, both ctrl fields go to 0, and any simultaneous accept is discarded. Data fields keep their old values.
- out_ctrl is gated to 0 when main is not valid, so a bubble presents all-zero control.
- stall_cnt increments in every cycle with out_valid & !out_ready, including a cycle that also has flush.
- flush_cnt increments in a flush cycle if any entry was valid.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, flush_cnt=0, state EMPTY, skid cleared.
- Latency: 1 cycle. Data accepted at edge N appears on out_* after edge N (EMPTY or FULL-with-drain path).
- Throughput: 1 entry/cycle while out_ready=1.
- out_ready falling: absorbs at most one extra entry (skid). in_ready drops the cycle after that.
- out_ready rising in SKID: main drains, skid→main, in_ready returns to 1 next cycle; no bubble.
- Reset mid-operation: all entries dropped immediately and asynchronously. Outputs go to reset values without waiting for a clock edge.
- Flush and rst are independent. Flush never clears the counters.

## Structure
- Shared package pipe_pkg: state typedef (EMPTY/FULL/SKID) and a CTRL_BUBBLE constant (all zeros).
- Sub-module sat_counter (parameter W; inputs inc, rst; output count), instantiated twice.
- Stage-specific control packing (RegWrite, MemToReg, AluOp bit positions) is done by the instantiating top, not inside this block.

## Test plan
- Streaming: out_ready=1, 8 back-to-back entries data 0x10..0x17 -> same order, 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles while streaming -> one entry held in skid, in_ready=0 from the second stall cycle, stall_cnt=3, none lost or duplicated after release.
- Flush in SKID with ctrl=0xFF and concurrent in_valid -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, flush_cnt=1, flushed input never emerges.
- Flush while EMPTY -> flush_cnt stays 0, state EMPTY.
- Async rst asserted mid-stream between edges -> out_valid and out_ctrl go to 0 before the next edge, counters reset to 0.
- Saturation with CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt sticks at 15.
